// File: rtl/memory_wait.sv
// memory_wait: single-port synchronous RAM with a req/ack handshake,
// a fixed number of programmable wait states per access and a bulk-clear
// sequence that zeroes every word. Separate read and write data buses.
module memory_wait #(
  parameter int AWIDTH      = 5,
  parameter int DWIDTH      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              clr,
  output logic [DWIDTH-1:0] rdata,
  output logic              ack,
  output logic              busy
);

  localparam int DEPTH = 2 ** AWIDTH;

  // Wait counter load value; unused when there are no wait states.
  localparam logic [7:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 8'd0 : 8'(WAIT_CYCLES - 1);

  // Clear counter is one bit wider than the address so the terminal
  // address is compared without the counter ever wrapping back to 0.
  localparam logic [AWIDTH:0] CLR_LAST = {1'b0, {AWIDTH{1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  state_t            state_reg;
  logic [7:0]        wait_cnt_reg;
  logic [AWIDTH:0]   clr_cnt_reg;
  logic              wr_reg;
  logic [AWIDTH-1:0] addr_reg;
  logic [DWIDTH-1:0] wdata_reg;

  // Storage array: never reset, contents undefined until written or cleared.
  logic [DWIDTH-1:0] mem [DEPTH];

  logic              take_req;
  logic              go_done;
  logic              acc_wr;
  logic [AWIDTH-1:0] acc_addr;
  logic [DWIDTH-1:0] acc_wdata;

  // Commit decode: the access is performed on the edge that enters DONE.
  // With no wait states that edge is the sampling edge itself, so the live
  // inputs are used; otherwise the latched copies are used.
  always_comb begin
    take_req = (state_reg == IDLE) && !clr && req;
    go_done  = (take_req && (WAIT_CYCLES == 0)) ||
               ((state_reg == WAIT) && (wait_cnt_reg == 8'd0));
    if (state_reg == IDLE) begin
      acc_wr    = wr;
      acc_addr  = addr;
      acc_wdata = wdata;
    end else begin
      acc_wr    = wr_reg;
      acc_addr  = addr_reg;
      acc_wdata = wdata_reg;
    end
  end

  // Control FSM with registered ack/busy, plus the array write/read ports.
  // Array accesses live in the non-reset branch so nothing is committed
  // while rst is held; the array itself has no reset values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      ack          <= 1'b0;
      busy         <= 1'b0;
      rdata        <= '0;
      wait_cnt_reg <= '0;
      clr_cnt_reg  <= '0;
      wr_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
    end else begin
      ack <= 1'b0;

      if (go_done) begin
        if (acc_wr) begin
          mem[acc_addr] <= acc_wdata;
        end else begin
          rdata <= mem[acc_addr];
        end
      end

      case (state_reg)
        IDLE: begin
          if (clr) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
            busy        <= 1'b1;
          end else if (req) begin
            wr_reg    <= wr;
            addr_reg  <= addr;
            wdata_reg <= wdata;
            busy      <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_reg <= DONE;
              ack       <= 1'b1;
            end else begin
              state_reg    <= WAIT;
              wait_cnt_reg <= WAIT_INIT;
            end
          end
        end

        WAIT: begin
          wait_cnt_reg <= wait_cnt_reg - 8'd1;
          if (wait_cnt_reg == 8'd0) begin
            state_reg <= DONE;
            ack       <= 1'b1;
          end
        end

        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end

        CLEAR: begin
          mem[clr_cnt_reg[AWIDTH-1:0]] <= '0;
          clr_cnt_reg <= clr_cnt_reg + (AWIDTH + 1)'(1);
          if (clr_cnt_reg == CLR_LAST) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
